// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Memory request/response, redirect and decoder channels of fetch.
// Revision : 1.0
// ============================================================================
interface fetch_if;
    import fetch_pkg::*;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_resp_valid;
    logic [INSTR_W-1:0] mem_resp_data;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_pc;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two synchronous FIFO with flush and occupancy output.
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC sequencer, credit-limited memory fetch and instruction buffer.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] ENTRY_PC   = RESET_PC,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH);

    fetch_state_t             state_q, state_d;
    logic [XLEN-1:0]          fetch_pc_q, fetch_pc_d;
    logic [CW:0]              drop_q, drop_d;
    logic                     run_q;

    logic [CW:0]              outstanding;
    logic [CW:0]              outstanding_after;
    logic [CW:0]              buf_count;
    logic [CW+1:0]            credit_used;
    logic [XLEN-1:0]          tag_pc;
    logic [XLEN+INSTR_W-1:0]  buf_rdata;
    logic                     req_valid;
    logic                     req_fire;
    logic                     resp_ok;
    logic                     resp_keep;
    logic                     instr_pop;
    logic                     unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // run_q holds requests off for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= ENTRY_PC;
            drop_q     <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            run_q      <= 1'b1;
        end
    end

    always_comb begin
        credit_used       = {1'b0, outstanding} + {1'b0, buf_count};
        req_valid         = run_q && (state_q == FETCH) &&
                            (credit_used < (CW+2)'(FIFO_DEPTH));
        req_fire          = req_valid && bus.mem_req_ready;
        resp_ok           = bus.mem_resp_valid && (outstanding != '0);
        resp_keep         = resp_ok && (drop_q == '0) && !bus.redirect_valid;
        instr_pop         = (buf_count != '0) && bus.instr_ready;
        outstanding_after = outstanding + (CW+1)'(req_fire) - (CW+1)'(resp_ok);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;

        if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - (CW+1)'(1);
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        // Every request still in flight after a redirect belongs to the old path.
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = outstanding_after;
        end

        case (state_q)
            FETCH: if (bus.redirect_valid && (drop_d != '0)) state_d = DRAIN;
            DRAIN: if (drop_d == '0)                         state_d = FETCH;
            default:                                         state_d = FETCH;
        endcase
    end

    // Tag queue occupancy doubles as the outstanding-request count.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (fetch_pc_q),
        .pop_i   (resp_ok),
        .rdata_o (tag_pc),
        .count_o (outstanding)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + INSTR_W)
    ) u_instr_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.redirect_valid),
        .push_i  (resp_keep),
        .wdata_i ({tag_pc, bus.mem_resp_data}),
        .pop_i   (instr_pop),
        .rdata_o (buf_rdata),
        .count_o (buf_count)
    );

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.instr_valid   = (buf_count != '0);
    assign bus.instr         = buf_rdata[INSTR_W-1:0];
    assign bus.instr_pc      = buf_rdata[XLEN+INSTR_W-1:INSTR_W];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench: cycle table, directed redirect/reset cases,
//            randomized traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] ENTRY = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus ();

    fetch_unit #(
        .ENTRY_PC   (ENTRY),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          rdy;
        bit          ir;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] ipc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    bit          d_ready, d_ir, d_redir, d_hold, d_spur;
    logic [31:0] d_rpc;
    int          d_extra_max;

    pend_t       pq[$];
    int          cyc;

    int          m_out, m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_buf[$];
    bit          m_first;

    bit          t_fire, t_pop, t_resp;
    logic [31:0] t_addr, t_pop_pc;
    bit          s_rv, s_iv;
    logic [31:0] s_addr, s_ipc, s_instr;
    bit          resp_cur;
    logic [31:0] resp_addr_cur;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at edge+1, check and advance the model at the falling edge.
    task automatic tick();
        bit exp_rv;
        bus.mem_req_ready  = d_ready;
        bus.instr_ready    = d_ir;
        bus.redirect_valid = d_redir;
        bus.redirect_pc    = d_rpc;
        resp_cur = 1'b0;
        if (!d_hold && pq.size() > 0 && pq[0].due <= cyc) begin
            resp_cur      = 1'b1;
            resp_addr_cur = pq[0].addr;
            void'(pq.pop_front());
        end
        bus.mem_resp_valid = resp_cur || d_spur;
        bus.mem_resp_data  = resp_cur ? memfn(resp_addr_cur) : (d_spur ? 32'hDEAD_BEEF : 32'h0);

        @(negedge clk);
        exp_rv = !m_first && (m_drop == 0) && ((m_out + m_buf.size()) < DEPTH);
        s_rv    = bus.mem_req_valid;
        s_addr  = bus.mem_req_addr;
        s_iv    = bus.instr_valid;
        s_ipc   = bus.instr_pc;
        s_instr = bus.instr;
        chk("mem_req_valid", 32'(s_rv), 32'(exp_rv));
        chk("mem_req_addr", s_addr, m_pc);
        chk("instr_valid", 32'(s_iv), 32'(m_buf.size() != 0));
        if (s_iv && m_buf.size() != 0) begin
            chk("instr_pc", s_ipc, m_buf[0]);
            chk("instr", s_instr, memfn(m_buf[0]));
        end
        t_fire   = s_rv && d_ready;
        t_addr   = s_addr;
        t_pop    = s_iv && d_ir;
        t_pop_pc = s_ipc;
        t_resp   = resp_cur;

        if (t_pop && m_buf.size() != 0) void'(m_buf.pop_front());
        if (resp_cur) begin
            m_out--;
            if (m_drop > 0)    m_drop--;
            else if (!d_redir) m_buf.push_back(resp_addr_cur);
        end
        if (t_fire) begin
            m_out++;
            m_pc = m_pc + 32'd4;
        end
        if (d_redir) begin
            m_buf.delete();
            m_drop = m_out;
            m_pc   = {d_rpc[31:2], 2'b00};
        end
        m_first = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
        if (t_fire) pq.push_back('{t_addr, cyc + int'($urandom_range(d_extra_max, 0))});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, bus.mem_req_addr, ENTRY);
        chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, bus.instr, 32'd0);
        chk({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        d_ready = 0; d_ir = 0; d_redir = 0; d_hold = 0; d_spur = 0;
        d_rpc = 32'h0; d_extra_max = 0;
        bus.mem_req_ready = 0; bus.instr_ready = 0; bus.redirect_valid = 0;
        bus.redirect_pc = 32'h0; bus.mem_resp_valid = 0; bus.mem_resp_data = 32'h0;
        pq.delete(); m_buf.delete();
        m_out = 0; m_drop = 0; m_pc = ENTRY; m_first = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Three requests held in flight, then a redirect to 0x103 puts the unit in DRAIN.
    task automatic enter_drain();
        d_ready = 1; d_ir = 1; d_hold = 1;
        for (int k = 0; k < 20 && m_out < 3; k++) tick();
        chk("setup_three_outstanding", 32'(m_out), 32'd3);
        d_ready = 0; d_redir = 1; d_rpc = 32'h0000_0103;
        tick();
        d_redir = 0; d_hold = 0; d_ready = 1;
    endtask

    task automatic wait_fire(input string tag, output bit found);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (t_fire) found = 1;
        end
        chk({tag, "_fire_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (t_pop) found = 1;
        end
        chk({tag, "_pop_timeout"}, 32'(found), 32'd1);
        chk({tag, "_first_instr_pc"}, t_pop_pc, exp_pc);
    endtask

    vec_t tbl[16];

    initial begin
        bit found;
        bit prev_top;
        int drops;

        tbl[0]  = '{1, 1, 0, 32'd0,  0, 32'd0};
        tbl[1]  = '{1, 1, 1, 32'd0,  0, 32'd0};
        tbl[2]  = '{1, 1, 1, 32'd4,  0, 32'd0};
        tbl[3]  = '{1, 1, 1, 32'd8,  1, 32'd0};
        tbl[4]  = '{1, 1, 1, 32'd12, 1, 32'd4};
        tbl[5]  = '{1, 1, 1, 32'd16, 1, 32'd8};
        tbl[6]  = '{1, 0, 1, 32'd20, 1, 32'd12};
        tbl[7]  = '{1, 0, 1, 32'd24, 1, 32'd12};
        tbl[8]  = '{1, 0, 0, 32'd28, 1, 32'd12};
        tbl[9]  = '{1, 0, 0, 32'd28, 1, 32'd12};
        tbl[10] = '{1, 1, 0, 32'd28, 1, 32'd12};
        tbl[11] = '{1, 1, 1, 32'd28, 1, 32'd16};
        tbl[12] = '{1, 1, 1, 32'd32, 1, 32'd20};
        tbl[13] = '{1, 1, 1, 32'd36, 1, 32'd24};
        tbl[14] = '{1, 1, 1, 32'd40, 1, 32'd28};
        tbl[15] = '{1, 1, 1, 32'd44, 1, 32'd32};

        // Streaming from reset, then a decoder stall that fills the buffer.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d_ready = tbl[i].rdy;
            d_ir    = tbl[i].ir;
            tick();
            chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_instr_valid", i), 32'(s_iv), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("tbl%0d_instr_pc", i), s_ipc, tbl[i].ipc);
                chk($sformatf("tbl%0d_instr", i), s_instr, memfn(tbl[i].ipc));
            end
        end

        // Redirect with three in flight: all three discarded before 0x100 is fetched.
        do_reset();
        enter_drain();
        drops = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (t_fire) found = 1;
            else if (t_resp) drops++;
        end
        chk("redir_fire_timeout", 32'(found), 32'd1);
        chk("redir_first_addr", t_addr, 32'h0000_0100);
        chk("redir_drops_before_fetch", 32'(drops), 32'd3);
        wait_pop("redir", 32'h0000_0100);

        // Second redirect while draining: 0x200 wins, 0x100 is never requested.
        do_reset();
        enter_drain();
        tick();
        d_redir = 1; d_rpc = 32'h0000_0200;
        tick();
        d_redir = 0;
        wait_fire("drain_redir", found);
        chk("drain_redir_first_addr", t_addr, 32'h0000_0200);
        wait_pop("drain_redir", 32'h0000_0200);

        // Redirect coinciding with a pop while two entries are buffered.
        do_reset();
        d_ready = 1; d_ir = 0;
        for (int k = 0; k < 20 && m_buf.size() < 2; k++) tick();
        chk("pop_redir_setup_two_buffered", 32'(m_buf.size()), 32'd2);
        d_ir = 1; d_redir = 1; d_rpc = 32'h0000_0300;
        tick();
        chk("pop_redir_pop_taken", 32'(t_pop), 32'd1);
        d_redir = 0;
        tick();
        chk("pop_redir_valid_after", 32'(s_iv), 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (t_pop) chk("pop_redir_no_stale_pc", {8'h0, t_pop_pc[31:8]}, 32'h3);
        end

        // Address wrap at the top of the address space.
        do_reset();
        d_ready = 1; d_ir = 1;
        repeat (3) tick();
        d_redir = 1; d_rpc = 32'hFFFF_FFF2;
        tick();
        d_redir = 0;
        found = 0;
        prev_top = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (t_fire) begin
                if (prev_top) begin
                    found = 1;
                    chk("wrap_addr", t_addr, 32'h0000_0000);
                end
                prev_top = (t_addr == 32'hFFFF_FFFC);
            end
        end
        chk("wrap_timeout", 32'(found), 32'd1);

        // Asynchronous reset in the middle of DRAIN, then a stray response.
        do_reset();
        enter_drain();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        do_reset();
        d_ready = 1; d_ir = 1; d_spur = 1;
        tick();
        d_spur = 0;
        wait_pop("restart", ENTRY);

        // Randomized traffic against the model.
        do_reset();
        d_extra_max = 2;
        for (int k = 0; k < 1500; k++) begin
            d_ready = ($urandom_range(3, 0) != 0);
            d_ir    = ($urandom_range(9, 0) < 7);
            d_redir = ($urandom_range(29, 0) == 0);
            d_rpc   = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_unit
`default_nettype wire
